rename_query: RTL and testbench
===============================

RENAME_QUERY -- requirements
Module: rename_query

Interface
REQ-001 SHALL have parameter ARCH_REGS, default 32, the architectural register count (x0 included).
REQ-002 SHALL have parameter TAGS, default 64, the rename tag count; tag 0 means "value in architectural file / none available".
REQ-003 i_clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 i_query_input_regs[2]  in  registers_t  per slot: rs_1, rs_2, rd arch indices (5b each).
REQ-006 i_valid[2]  in  1  slot holds a decoded instruction.
REQ-007 i_writes[2]  in  1  slot writes rd.
REQ-008 i_halt  in  1  suppresses all allocation this cycle.
REQ-009 i_commit_valid[2]  in  1  retiring slot frees a tag.
REQ-010 i_commit_tag[2], i_commit_rd[2]  in  6, 5  retiring tag and its arch rd.
REQ-011 i_flush  in  1  synchronous flush of all speculative renames.
REQ-012 o_query_output_regs[2]  out  registers_t  per slot: rs_1, rs_2 tags, rn allocated tag.
REQ-013 o_free_count  out  7  tags currently in the free list.
REQ-014 o_panic  out  1  sticky protocol-error flag.

Function
REQ-015 Alias table (ARCH_REGS x 6b) SHALL map each arch register to its newest tag; entry 0 SHALL always read 0.
REQ-016 Query SHALL be combinational: rs_1/rs_2 outputs = table[rs] as of cycle start, for both slots; no intra-pair bypass (downstream Resolver handles slot0.rd -> slot1.rs).
REQ-017 need[k] = i_valid[k] & i_writes[k] & (rd[k] != 0); tags SHALL be peeked from free-list head: first needer gets head, second gets head+1.
REQ-018 Allocation all-or-nothing: if free count < need[0]+need[1], both rn outputs SHALL be 0 and nothing popped.
REQ-019 rn SHALL be 0 for any slot with need=0.
REQ-020 On clock edge with allocation granted and !i_halt & !i_flush: pop needed tags, write table[rd[k]] = rn[k]; if rd[0]==rd[1], slot 1 tag SHALL win.
REQ-021 Commit: each valid commit pushes its tag at free-list tail (slot 0 first); if table[commit_rd]==commit_tag, entry SHALL clear to 0.
REQ-022 Same-cycle commit-clear and rename of same rd: rename write SHALL win.
REQ-023 Tags freed in cycle N SHALL be allocatable no earlier than cycle N+1; count update = count - pops + pushes.
REQ-024 Free list SHALL be a 64-deep circular FIFO, 6b head/tail wrapping 63->0, holding at most TAGS-1 tags.
REQ-025 i_flush SHALL restore reset state next edge (table all 0, list full 1..63, count 63) and override alloc/commit that cycle; o_panic SHALL be unaffected.
REQ-026 o_panic SHALL set and hold on: commit of tag 0, or push making count exceed 63.

Reset
REQ-027 On i_reset: table all 0; free list holds 1..63 in order, head=0, tail=63; o_free_count=63; o_panic=0; rn outputs 0.
REQ-028 Reset mid-allocation SHALL discard the pending pop and table write.

Structure
REQ-029 registers_t, ARCH_REGS, TAGS, tag/index widths SHALL live in pkg_defines.
REQ-030 Free-list FIFO (2-pop peek, 2-push, count) SHALL be sub-module free_list; alias table stays in rename_query.

Verification
REQ-031 Reset, slot0 add x5, slot1 add x6 -> rn 1,2; next cycle query rs_1=x5 -> 1; count 61.
REQ-032 Both slots rd=x7 -> rn 1,2; table[x7]=2; count 61.
REQ-033 Drain to count 1, two writers -> both rn 0, count stays 1; one writer -> rn granted, count 0.
REQ-034 Commit tag 1 rd x5 while table[x5]=1 -> table[x5]=0, count +1 next cycle; same cycle rename x5 -> new tag kept.
REQ-035 Allocate 70 tags over time with steady commits -> head wraps 63->0, no panic; commit tag 0 -> o_panic=1 and holds.
REQ-036 i_flush after 10 renames -> table 0, count 63; async reset mid-cycle -> outputs reset immediately.

Source files
------------

// File: rtl/pkg_defines.sv
// Shared rename-stage types and sizes.
// Register bundle is sized to carry either an arch index or a tag.
package pkg_defines;

  localparam int ARCH_REGS = 32;
  localparam int TAGS      = 64;
  localparam int ARCH_W    = 5;
  localparam int TAG_W     = 6;
  localparam int CNT_W     = 7;

  // Inbound: rs_1/rs_2/rd are arch indices (bit 5 must be 0).
  // Outbound: rs_1/rs_2 are source tags, rd carries the new tag.
  typedef struct packed {
    logic [TAG_W-1:0] rs_1;
    logic [TAG_W-1:0] rs_2;
    logic [TAG_W-1:0] rd;
  } registers_t;

endpackage

// File: rtl/free_list.sv
// Circular tag FIFO: two-entry peek at head, two pushes at tail.
// Pushes land at the tail, so a freed tag is never peeked same cycle.
module free_list
  import pkg_defines::*;
#(
  parameter int TAGS = pkg_defines::TAGS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       pop_cnt,
  input  logic [1:0]       push_valid,
  input  logic [TAG_W-1:0] push_tag [2],
  output logic [TAG_W-1:0] peek_tag [2],
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [TAG_W-1:0] mem [TAGS];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W-1:0] tail_1;
  logic [1:0]       n_push;
  logic [CNT_W-1:0] count_next;

  // Head peek, second push slot and next occupancy.
  always_comb begin
    n_push      = {1'b0, push_valid[0]} + {1'b0, push_valid[1]};
    count_next  = count - CNT_W'(pop_cnt) + CNT_W'(n_push);
    overflow    = count_next > CNT_W'(TAGS - 1);
    peek_tag[0] = mem[head];
    peek_tag[1] = mem[head + TAG_W'(1)];
    tail_1      = push_valid[0] ? tail + TAG_W'(1) : tail;
  end

  // Reset and flush refill 1..TAGS-1; last slot left empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAGS; i++)
        mem[i] <= TAG_W'(i + 1);
      head  <= '0;
      tail  <= TAG_W'(TAGS - 1);
      count <= CNT_W'(TAGS - 1);
    end else if (flush) begin
      for (int i = 0; i < TAGS; i++)
        mem[i] <= TAG_W'(i + 1);
      head  <= '0;
      tail  <= TAG_W'(TAGS - 1);
      count <= CNT_W'(TAGS - 1);
    end else begin
      if (push_valid[0])
        mem[tail] <= push_tag[0];
      if (push_valid[1])
        mem[tail_1] <= push_tag[1];
      head  <= head + TAG_W'(pop_cnt);
      tail  <= tail + TAG_W'(n_push);
      count <= count_next;
    end
  end

endmodule

// File: rtl/rename_query.sv
// Two-wide rename: alias-table lookup plus free-list allocation.
// Same-pair rd->rs dependencies are resolved further downstream.
module rename_query
  import pkg_defines::*;
#(
  parameter int ARCH_REGS = pkg_defines::ARCH_REGS,
  parameter int TAGS      = pkg_defines::TAGS
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  registers_t       i_query_input_regs [2],
  input  logic [1:0]       i_valid,
  input  logic [1:0]       i_writes,
  input  logic             i_halt,
  input  logic [1:0]       i_commit_valid,
  input  logic [TAG_W-1:0] i_commit_tag [2],
  input  logic [ARCH_W-1:0] i_commit_rd [2],
  input  logic             i_flush,
  output registers_t       o_query_output_regs [2],
  output logic [CNT_W-1:0] o_free_count,
  output logic             o_panic
);

  logic [TAG_W-1:0]  alias_q [ARCH_REGS];
  logic [TAG_W-1:0]  peek [2];
  logic [TAG_W-1:0]  rn [2];
  logic [ARCH_W-1:0] rd_idx [2];
  logic [1:0]        need;
  logic [1:0]        total;
  logic              grant;
  logic              alloc_ok;
  logic              do_alloc;
  logic [1:0]        pop_cnt;
  logic [1:0]        push_valid;
  logic              overflow;
  logic              panic_set;
  logic              panic_q;

  // Decide which slots need a tag and whether the pair fits.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rd_idx[k] = i_query_input_regs[k].rd[ARCH_W-1:0];
      need[k]   = i_valid[k] & i_writes[k]
                & (i_query_input_regs[k].rd != '0)
                & (i_query_input_regs[k].rd < TAG_W'(ARCH_REGS));
    end
    total    = {1'b0, need[0]} + {1'b0, need[1]};
    grant    = o_free_count >= CNT_W'(total);
    alloc_ok = grant & ~i_halt & ~i_reset;
    do_alloc = alloc_ok & ~i_flush;
    pop_cnt  = do_alloc ? total : 2'd0;
    rn[0]    = (need[0] & alloc_ok) ? peek[0] : '0;
    rn[1]    = '0;
    if (need[1] & alloc_ok)
      rn[1] = need[0] ? peek[1] : peek[0];
  end

  // Source lookup from start-of-cycle table; x0 always tag 0.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      o_query_output_regs[k] = '0;
      if (i_query_input_regs[k].rs_1 != '0 &&
          i_query_input_regs[k].rs_1 < TAG_W'(ARCH_REGS))
        o_query_output_regs[k].rs_1 =
          alias_q[i_query_input_regs[k].rs_1[ARCH_W-1:0]];
      if (i_query_input_regs[k].rs_2 != '0 &&
          i_query_input_regs[k].rs_2 < TAG_W'(ARCH_REGS))
        o_query_output_regs[k].rs_2 =
          alias_q[i_query_input_regs[k].rs_2[ARCH_W-1:0]];
      o_query_output_regs[k].rd = rn[k];
    end
  end

  // Tag 0 is never returned to the list; it only raises panic.
  always_comb begin
    panic_set = 1'b0;
    for (int k = 0; k < 2; k++) begin
      push_valid[k] = i_commit_valid[k] & (i_commit_tag[k] != '0)
                    & ~i_flush;
      if (i_commit_valid[k] && i_commit_tag[k] == '0 && !i_flush)
        panic_set = 1'b1;
    end
    if (overflow && !i_flush)
      panic_set = 1'b1;
  end

  free_list #(
    .TAGS(TAGS)
  ) u_free_list (
    .clk       (i_clock),
    .rst       (i_reset),
    .flush     (i_flush),
    .pop_cnt   (pop_cnt),
    .push_valid(push_valid),
    .push_tag  (i_commit_tag),
    .peek_tag  (peek),
    .count     (o_free_count),
    .overflow  (overflow)
  );

  // Commit clears first, then renames overwrite (slot 1 last).
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < ARCH_REGS; i++)
        alias_q[i] <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < ARCH_REGS; i++)
        alias_q[i] <= '0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (push_valid[k] &&
            alias_q[i_commit_rd[k]] == i_commit_tag[k])
          alias_q[i_commit_rd[k]] <= '0;
      if (do_alloc)
        for (int k = 0; k < 2; k++)
          if (need[k])
            alias_q[rd_idx[k]] <= rn[k];
    end
  end

  // Sticky protocol error; only reset clears it.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)
      panic_q <= 1'b0;
    else if (panic_set)
      panic_q <= 1'b1;
  end

  assign o_panic = panic_q;

endmodule

// File: tb/tb_rename_query.sv
// Scoreboard bench for rename_query.
// A queue-based reference model predicts tags, table and count.
module tb_rename_query;
  import pkg_defines::*;

  logic             i_clock = 1'b0;
  logic             i_reset;
  registers_t       qin [2];
  logic [1:0]       i_valid;
  logic [1:0]       i_writes;
  logic             i_halt;
  logic [1:0]       i_commit_valid;
  logic [TAG_W-1:0] i_commit_tag [2];
  logic [ARCH_W-1:0] i_commit_rd [2];
  logic             i_flush;
  registers_t       qout [2];
  logic [CNT_W-1:0] o_free_count;
  logic             o_panic;

  rename_query dut (
    .i_clock            (i_clock),
    .i_reset            (i_reset),
    .i_query_input_regs (qin),
    .i_valid            (i_valid),
    .i_writes           (i_writes),
    .i_halt             (i_halt),
    .i_commit_valid     (i_commit_valid),
    .i_commit_tag       (i_commit_tag),
    .i_commit_rd        (i_commit_rd),
    .i_flush            (i_flush),
    .o_query_output_regs(qout),
    .o_free_count       (o_free_count),
    .o_panic            (o_panic)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    int rn0; int rn1;
    int q00; int q01; int q10; int q11;
    int cnt; int pan;
  } exp_t;

  typedef struct { int tag; int rd; } inf_t;

  int   m_tab [32];
  int   m_fl [$];
  bit   m_panic;
  inf_t inflight [$];
  exp_t sb [$];
  exp_t got;
  int   checks;
  int   errors;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_tab[i] = 0;
    m_fl.delete();
    for (int i = 1; i < 64; i++) m_fl.push_back(i);
    inflight.delete();
  endfunction

  function automatic int need_of(input int k);
    return (i_valid[k] && i_writes[k] && qin[k].rd != 0) ? 1 : 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int n0, n1;
    bit g;
    n0 = need_of(0);
    n1 = need_of(1);
    g = (m_fl.size() >= n0 + n1) && !i_halt;
    e.rn0 = (n0 != 0 && g) ? m_fl[0] : 0;
    e.rn1 = 0;
    if (n1 != 0 && g) e.rn1 = (n0 != 0) ? m_fl[1] : m_fl[0];
    e.q00 = m_tab[qin[0].rs_1];
    e.q01 = m_tab[qin[0].rs_2];
    e.q10 = m_tab[qin[1].rs_1];
    e.q11 = m_tab[qin[1].rs_2];
    e.cnt = m_fl.size();
    e.pan = m_panic;
    return e;
  endfunction

  function automatic void model_update();
    int old_tab [32];
    int pushes [$];
    int n0, n1, t;
    if (i_flush) begin
      model_reset();
      return;
    end
    old_tab = m_tab;
    for (int k = 0; k < 2; k++)
      if (i_commit_valid[k]) begin
        if (i_commit_tag[k] == 0) m_panic = 1;
        else begin
          pushes.push_back(int'(i_commit_tag[k]));
          if (old_tab[i_commit_rd[k]] == int'(i_commit_tag[k]))
            m_tab[i_commit_rd[k]] = 0;
        end
      end
    n0 = need_of(0);
    n1 = need_of(1);
    if (!i_halt && m_fl.size() >= n0 + n1) begin
      if (n0 != 0) begin
        t = m_fl.pop_front();
        m_tab[qin[0].rd] = t;
        inflight.push_back('{t, int'(qin[0].rd)});
      end
      if (n1 != 0) begin
        t = m_fl.pop_front();
        m_tab[qin[1].rd] = t;
        inflight.push_back('{t, int'(qin[1].rd)});
      end
    end
    foreach (pushes[i]) begin
      m_fl.push_back(pushes[i]);
      if (m_fl.size() > 63) m_panic = 1;
    end
  endfunction

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      qin[k] = '0;
      i_commit_tag[k] = '0;
      i_commit_rd[k] = '0;
    end
    i_valid = '0;
    i_writes = '0;
    i_halt = 1'b0;
    i_commit_valid = '0;
    i_flush = 1'b0;
  endtask

  task automatic set_slot(input int k, input bit v, input bit w,
                          input int rd, input int rs1, input int rs2);
    i_valid[k] = v;
    i_writes[k] = w;
    qin[k].rd = TAG_W'(rd);
    qin[k].rs_1 = TAG_W'(rs1);
    qin[k].rs_2 = TAG_W'(rs2);
  endtask

  task automatic set_commit(input int k, input int tag, input int rd);
    i_commit_valid[k] = 1'b1;
    i_commit_tag[k] = TAG_W'(tag);
    i_commit_rd[k] = ARCH_W'(rd);
    for (int i = 0; i < inflight.size(); i++)
      if (inflight[i].tag == tag) begin
        inflight.delete(i);
        break;
      end
  endtask

  task automatic cycle();
    exp_t e;
    sb.push_back(model_out());
    #1;
    got.rn0 = qout[0].rd;  got.rn1 = qout[1].rd;
    got.q00 = qout[0].rs_1; got.q01 = qout[0].rs_2;
    got.q10 = qout[1].rs_1; got.q11 = qout[1].rs_2;
    got.cnt = o_free_count; got.pan = o_panic;
    e = sb.pop_front();
    check_eq("sb_rn0", got.rn0, e.rn0);
    check_eq("sb_rn1", got.rn1, e.rn1);
    check_eq("sb_q00", got.q00, e.q00);
    check_eq("sb_q01", got.q01, e.q01);
    check_eq("sb_q10", got.q10, e.q10);
    check_eq("sb_q11", got.q11, e.q11);
    check_eq("sb_cnt", got.cnt, e.cnt);
    check_eq("sb_pan", got.pan, e.pan);
    @(posedge i_clock);
    model_update();
    @(negedge i_clock);
  endtask

  task automatic flush_cycle();
    idle();
    i_flush = 1'b1;
    cycle();
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    i_reset = 1'b1;
    m_panic = 0;
    model_reset();
    #3;
    check_eq("rst_count", int'(o_free_count), 63);
    check_eq("rst_panic", int'(o_panic), 0);
    check_eq("rst_rn0", int'(qout[0].rd), 0);
    @(negedge i_clock);
    i_reset = 1'b0;

    // Two writers to different rd
    set_slot(0, 1, 1, 5, 0, 0);
    set_slot(1, 1, 1, 6, 0, 0);
    cycle();
    check_eq("r31_rn0", got.rn0, 1);
    check_eq("r31_rn1", got.rn1, 2);
    idle();
    set_slot(0, 1, 0, 0, 5, 6);
    cycle();
    check_eq("r31_q5", got.q00, 1);
    check_eq("r31_cnt", got.cnt, 61);

    // Both slots write the same rd
    flush_cycle();
    set_slot(0, 1, 1, 7, 0, 0);
    set_slot(1, 1, 1, 7, 0, 0);
    cycle();
    check_eq("r32_rn0", got.rn0, 1);
    check_eq("r32_rn1", got.rn1, 2);
    idle();
    set_slot(0, 1, 0, 0, 7, 0);
    cycle();
    check_eq("r32_q7", got.q00, 2);
    check_eq("r32_cnt", got.cnt, 61);

    // Drain to one tag, then all-or-nothing
    flush_cycle();
    for (int i = 0; i < 31; i++) begin
      set_slot(0, 1, 1, i + 1, 0, 0);
      set_slot(1, 1, 1, 31 - i, 0, 0);
      cycle();
    end
    cycle();
    check_eq("r33_cnt1", got.cnt, 1);
    check_eq("r33_rn0", got.rn0, 0);
    check_eq("r33_rn1", got.rn1, 0);
    idle();
    set_slot(1, 1, 1, 9, 0, 0);
    cycle();
    check_eq("r33_one", got.rn1, 63);
    idle();
    cycle();
    check_eq("r33_cnt0", got.cnt, 0);

    // Commit clears matching entry; rename wins same cycle
    flush_cycle();
    set_slot(0, 1, 1, 5, 0, 0);
    cycle();
    check_eq("r34_rn", got.rn0, 1);
    idle();
    set_commit(0, 1, 5);
    set_slot(0, 1, 0, 0, 5, 0);
    cycle();
    check_eq("r34_qold", got.q00, 1);
    check_eq("r34_cnt62", got.cnt, 62);
    idle();
    set_slot(0, 1, 0, 0, 5, 0);
    cycle();
    check_eq("r34_qclr", got.q00, 0);
    check_eq("r34_cnt63", got.cnt, 63);
    set_slot(0, 1, 1, 5, 5, 0);
    cycle();
    check_eq("r34_rn2", got.rn0, 2);
    idle();
    set_commit(0, 2, 5);
    set_slot(0, 1, 1, 5, 5, 0);
    cycle();
    check_eq("r34_rn3", got.rn0, 3);
    idle();
    set_slot(0, 1, 0, 0, 5, 0);
    cycle();
    check_eq("r34_keep", got.q00, 3);

    // Long run: head wraps with steady commits
    flush_cycle();
    for (int i = 0; i < 70; i++) begin
      idle();
      set_slot(0, 1, 1, (i % 31) + 1, (i % 31) + 1, 0);
      if (inflight.size() >= 2)
        set_commit(0, inflight[0].tag, inflight[0].rd);
      cycle();
    end
    check_eq("r35_wrap_rn", got.rn0 != 0 ? 1 : 0, 1);
    check_eq("r35_nopanic", got.pan, 0);
    idle();
    set_commit(1, 0, 3);
    cycle();
    idle();
    cycle();
    check_eq("r35_panic", got.pan, 1);
    cycle();
    check_eq("r35_hold", got.pan, 1);

    // Flush after ten renames
    flush_cycle();
    for (int i = 0; i < 5; i++) begin
      set_slot(0, 1, 1, 2 * i + 1, 0, 0);
      set_slot(1, 1, 1, 2 * i + 2, 0, 0);
      cycle();
    end
    flush_cycle();
    set_slot(0, 1, 0, 0, 1, 2);
    set_slot(1, 1, 0, 0, 9, 10);
    cycle();
    check_eq("r36_cnt", got.cnt, 63);
    check_eq("r36_q1", got.q00, 0);
    check_eq("r36_q10", got.q11, 0);
    check_eq("r36_pan", got.pan, 1);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      idle();
      set_slot(0, $urandom_range(1), $urandom_range(1),
               $urandom_range(31), $urandom_range(31),
               $urandom_range(31));
      set_slot(1, $urandom_range(1), $urandom_range(1),
               $urandom_range(31), $urandom_range(31),
               $urandom_range(31));
      i_halt = ($urandom_range(7) == 0);
      if (inflight.size() > 3 && $urandom_range(1) == 1)
        set_commit(0, inflight[0].tag, inflight[0].rd);
      if (inflight.size() > 3 && $urandom_range(1) == 1)
        set_commit(1, inflight[0].tag, inflight[0].rd);
      cycle();
    end

    // Async reset mid-cycle with an allocation pending
    idle();
    set_slot(0, 1, 1, 4, 4, 0);
    set_slot(1, 1, 1, 8, 0, 0);
    #3;
    i_reset = 1'b1;
    #1;
    check_eq("ar_cnt", int'(o_free_count), 63);
    check_eq("ar_rn0", int'(qout[0].rd), 0);
    check_eq("ar_rn1", int'(qout[1].rd), 0);
    check_eq("ar_q", int'(qout[0].rs_1), 0);
    check_eq("ar_pan", int'(o_panic), 0);
    @(posedge i_clock);
    #2;
    i_reset = 1'b0;
    idle();
    model_reset();
    m_panic = 0;
    @(negedge i_clock);
    set_slot(0, 1, 1, 4, 4, 8);
    cycle();
    check_eq("ar_after", got.rn0, 1);
    check_eq("ar_cnt2", got.cnt, 63);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
